// File: rtl/sdram_seq_pkg.sv
// Shared types and widths for the SDRAM host sequencer and its command FIFO.
package sdram_seq_pkg;

   localparam int unsigned ADDR_W = 22;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } seq_state_t;

   // Queued command layout: {wr, addr, data}
   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   function automatic cmd_t pack_cmd(input logic              wr,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [DATA_W-1:0] data);
      cmd_t c;
      c.wr   = wr;
      c.addr = addr;
      c.data = data;
      return c;
   endfunction

endpackage

// File: rtl/sdram_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags. The pointers carry one
// extra wrap bit so full and empty can be told apart without a counter.
module sdram_cmd_fifo
   import sdram_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = CMD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                  (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign head  = mem[rd_ptr[IDX_W-1:0]];

   // Pointer update; reset discards everything queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Storage write; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IDX_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/sdram_host_sequencer.sv
// Host-side command sequencer for the SDRAM multiplexer (select 0).
// Buffers single-word read/write commands and issues them one at a time on
// the host RD/WR/Done handshake, only while the multiplexer grants the port.
// Optional feature macro: SEQ_TIMEOUT_EN (abort a request after TIMEOUT
// cycles without Done and raise sticky oERR).
module sdram_host_sequencer
   import sdram_seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iCMD_VALID,
   output logic              oCMD_READY,
   input  logic [ADDR_W-1:0] iCMD_ADDR,
   input  logic [DATA_W-1:0] iCMD_DATA,
   input  logic              iCMD_WR,
   output logic              oRSP_VALID,
   output logic [DATA_W-1:0] oRSP_DATA,
   input  logic              iGRANT,
   output logic [ADDR_W-1:0] oHS_ADDR,
   output logic [DATA_W-1:0] oHS_DATA,
   output logic              oHS_RD,
   output logic              oHS_WR,
   input  logic [DATA_W-1:0] iHS_DATA,
   input  logic              iHS_Done,
   output logic              oBUSY,
   output logic              oERR
);

   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

   seq_state_t        state;
   seq_state_t        state_next;
   cmd_t              head;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              load;
   logic              rd_next;
   logic              wr_next;
   logic              rsp_load;
   logic              hs_rd;
   logic              hs_wr;
   logic [ADDR_W-1:0] hs_addr;
   logic [DATA_W-1:0] hs_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [GAP_W-1:0]  gap_cnt;
   logic              gap_expired;

   assign push = iCMD_VALID && !full;

   sdram_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (iCLK),
      .rst   (iRST),
      .push  (push),
      .pop   (pop),
      .wdata (pack_cmd(iCMD_WR, iCMD_ADDR, iCMD_DATA)),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign gap_expired = (32'(gap_cnt) + 32'd1) >= GAP_CYCLES;

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 2);

   logic [TO_W-1:0] to_cnt;
   logic            to_expired;
   logic            err_set;
   logic            err;

   assign to_expired = (32'(to_cnt) + 32'd1) >= TIMEOUT;

   // Timeout counter restarts on every entry to REQ.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         to_cnt <= '0;
      end else if (state != ST_REQ) begin
         to_cnt <= '0;
      end else if (!to_expired) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end
   end

   assign oERR = err;
`else
   assign oERR = 1'b0;
`endif

   // Next-state and request-line decisions.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load       = 1'b0;
      rd_next    = hs_rd;
      wr_next    = hs_wr;
      rsp_load   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      err_set    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (!empty && iGRANT) begin
               load       = 1'b1;
               rd_next    = !head.wr;
               wr_next    = head.wr;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            // Done is forced high by the mux when not granted, so grant loss
            // is checked first and the command stays queued for a retry.
            if (!iGRANT) begin
               rd_next    = 1'b0;
               wr_next    = 1'b0;
               state_next = ST_IDLE;
            end else if (iHS_Done) begin
               rd_next    = 1'b0;
               wr_next    = 1'b0;
               pop        = 1'b1;
               rsp_load   = hs_rd;
               state_next = ST_GAP;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (to_expired) begin
               rd_next    = 1'b0;
               wr_next    = 1'b0;
               pop        = 1'b1;
               err_set    = 1'b1;
               state_next = ST_GAP;
            end
`endif
         end
         ST_GAP: begin
            // A Done still high from the last request must not leak into the next.
            if (gap_expired && !iHS_Done) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            rd_next    = 1'b0;
            wr_next    = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Host request lines, request address/data and read response registers.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         hs_rd     <= 1'b0;
         hs_wr     <= 1'b0;
         hs_addr   <= '0;
         hs_data   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         hs_rd     <= rd_next;
         hs_wr     <= wr_next;
         rsp_valid <= rsp_load;
         if (load) begin
            hs_addr <= head.addr;
            hs_data <= head.data;
         end
         if (rsp_load) begin
            rsp_data <= iHS_DATA;
         end
      end
   end

   // Inter-request gap counter, held at zero outside GAP.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         gap_cnt <= '0;
      end else if (state != ST_GAP) begin
         gap_cnt <= '0;
      end else if (!gap_expired) begin
         gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

   assign oCMD_READY = !full;
   assign oBUSY      = !empty || (state != ST_IDLE);
   assign oHS_RD     = hs_rd;
   assign oHS_WR     = hs_wr;
   assign oHS_ADDR   = hs_addr;
   assign oHS_DATA   = hs_data;
   assign oRSP_VALID = rsp_valid;
   assign oRSP_DATA  = rsp_data;

endmodule

// File: tb/tb_sdram_host_sequencer.sv
// Directed self-checking bench for sdram_host_sequencer.
module tb_sdram_host_sequencer;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [21:0] cmd_addr;
   logic [15:0] cmd_data;
   logic        cmd_wr;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        grant;
   logic [21:0] hs_addr;
   logic [15:0] hs_data;
   logic        hs_rd;
   logic        hs_wr;
   logic [15:0] hs_rdata;
   logic        hs_done;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   sdram_host_sequencer #(
      .FIFO_DEPTH (4),
      .GAP_CYCLES (2),
      .TIMEOUT    (16)
   ) dut (
      .iCLK       (clk),
      .iRST       (rst),
      .iCMD_VALID (cmd_valid),
      .oCMD_READY (cmd_ready),
      .iCMD_ADDR  (cmd_addr),
      .iCMD_DATA  (cmd_data),
      .iCMD_WR    (cmd_wr),
      .oRSP_VALID (rsp_valid),
      .oRSP_DATA  (rsp_data),
      .iGRANT     (grant),
      .oHS_ADDR   (hs_addr),
      .oHS_DATA   (hs_data),
      .oHS_RD     (hs_rd),
      .oHS_WR     (hs_wr),
      .iHS_DATA   (hs_rdata),
      .iHS_Done   (hs_done),
      .oBUSY      (busy),
      .oERR       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic wr, input logic [21:0] a, input logic [15:0] d);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!(hs_rd || hs_wr)) begin
         tick();
         n++;
         if (n > 60) begin
            checks++;
            errors++;
            $display("FAIL %s: no request within 60 cycles", name);
            break;
         end
      end
   endtask

   // Waits until the DUT goes idle, counting cycles that show a request.
   task automatic wait_idle(input string name, output int extra);
      int n = 0;
      extra = 0;
      while (busy) begin
         tick();
         n++;
         if (hs_rd || hs_wr) extra++;
         if (n > 60) begin
            checks++;
            errors++;
            $display("FAIL %s: still busy after 60 cycles", name);
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_wr = 1'b0;
      grant = 1'b1; hs_rdata = '0; hs_done = 1'b0;
      tick();
      tick();
      checks++;
      if ({cmd_ready, rsp_valid, hs_rd, hs_wr, busy, err} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 100000", {cmd_ready, rsp_valid, hs_rd, hs_wr, busy, err});
      end
      checks++;
      if ({rsp_data, hs_addr, hs_data} !== 54'd0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", {rsp_data, hs_addr, hs_data});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write;
      push_cmd(1'b1, 22'h000010, 16'hA5A5);
      checks++;
      if (hs_wr !== 1'b0) begin errors++; $display("FAIL wr_latency: wr=%b want 0 one cycle after push", hs_wr); end
      tick();
      checks++;
      if ({hs_wr, hs_rd} !== 2'b10) begin errors++; $display("FAIL wr_issue: wr,rd=%b want 10", {hs_wr, hs_rd}); end
      checks++;
      if (hs_addr !== 22'h000010 || hs_data !== 16'hA5A5) begin
         errors++; $display("FAIL wr_addr_data: got %h/%h want 000010/a5a5", hs_addr, hs_data);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (hs_wr !== 1'b1) begin errors++; $display("FAIL wr_hold%0d: wr=%b want 1", i, hs_wr); end
      end
      hs_done = 1'b1;
      tick();
      hs_done = 1'b0;
      checks++;
      if ({hs_wr, rsp_valid, busy} !== 3'b001) begin
         errors++; $display("FAIL wr_done: wr,rsp_valid,busy=%b want 001", {hs_wr, rsp_valid, busy});
      end
      tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL wr_gap: busy=%b want 1", busy); end
      tick();
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL wr_idle: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_read;
      push_cmd(1'b0, 22'h3FFFFF, 16'h0000);
      tick();
      checks++;
      if ({hs_rd, hs_wr} !== 2'b10 || hs_addr !== 22'h3FFFFF) begin
         errors++; $display("FAIL rd_issue: rd,wr=%b addr=%h want 10 3fffff", {hs_rd, hs_wr}, hs_addr);
      end
      hs_rdata = 16'h1234;
      hs_done  = 1'b1;
      tick();
      hs_done  = 1'b0;
      hs_rdata = 16'hFFFF;
      checks++;
      if (hs_rd !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 16'h1234) begin
         errors++; $display("FAIL rd_rsp: rd=%b rsp_valid=%b data=%h want 0 1 1234", hs_rd, rsp_valid, rsp_data);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 16'h1234) begin
         errors++; $display("FAIL rd_hold: rsp_valid=%b data=%h want 0 1234", rsp_valid, rsp_data);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle: busy=%b want 0", busy); end
   endtask

   task automatic tick_bb;
      logic acc;
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) cmd_valid = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [21:0] a [5];
      logic [15:0] d [5];
      logic        w [5];
      int          idle;
      int          extra;
      for (int i = 0; i < 5; i++) begin
         a[i] = 22'h000100 + 22'(i);
         d[i] = 16'hB000 + 16'(i);
         w[i] = i[0];
      end
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_wr = w[i]; cmd_addr = a[i]; cmd_data = d[i];
         tick();
      end
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bb_full: ready=%b want 0 after 4 pushes", cmd_ready); end
      cmd_valid = 1'b1; cmd_wr = w[4]; cmd_addr = a[4]; cmd_data = d[4];
      for (int k = 0; k < 5; k++) begin
         idle = 0;
         while (!(hs_rd || hs_wr) && idle < 60) begin
            tick_bb();
            idle++;
         end
         if (k > 0) begin
            checks++;
            if (idle < 2 || idle >= 60) begin errors++; $display("FAIL bb_gap%0d: idle=%0d want >=2", k, idle); end
         end
         checks++;
         if (hs_addr !== a[k] || hs_wr !== w[k] || hs_rd !== !w[k]) begin
            errors++; $display("FAIL bb_order%0d: addr=%h wr=%b rd=%b want %h %b", k, hs_addr, hs_wr, hs_rd, a[k], w[k]);
         end
         if (w[k]) begin
            checks++;
            if (hs_data !== d[k]) begin errors++; $display("FAIL bb_wdata%0d: got %h want %h", k, hs_data, d[k]); end
         end
         hs_rdata = 16'hC000 + 16'(k);
         hs_done  = 1'b1;
         tick_bb();
         hs_done  = 1'b0;
         if (!w[k]) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'hC000 + 16'(k)) begin
               errors++; $display("FAIL bb_rsp%0d: valid=%b data=%h want 1 %h", k, rsp_valid, rsp_data, 16'hC000 + 16'(k));
            end
         end
      end
      wait_idle("bb_drain", extra);
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL bb_extra: %0d extra request cycles want 0", extra); end
   endtask

   task automatic test_grant_drop;
      int extra;
      push_cmd(1'b0, 22'h0ABCDE, 16'h0000);
      tick();
      checks++;
      if (hs_rd !== 1'b1) begin errors++; $display("FAIL gd_issue: rd=%b want 1", hs_rd); end
      grant   = 1'b0;
      hs_done = 1'b1;
      tick();
      checks++;
      if (hs_rd !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL gd_drop: rd=%b rsp_valid=%b want 0 0", hs_rd, rsp_valid);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({hs_rd, hs_wr, rsp_valid, busy} !== 4'b0001) begin
            errors++; $display("FAIL gd_wait%0d: rd,wr,rsp,busy=%b want 0001", i, {hs_rd, hs_wr, rsp_valid, busy});
         end
      end
      grant   = 1'b1;
      hs_done = 1'b0;
      tick();
      checks++;
      if (hs_rd !== 1'b1 || hs_addr !== 22'h0ABCDE) begin
         errors++; $display("FAIL gd_reissue: rd=%b addr=%h want 1 0abcde", hs_rd, hs_addr);
      end
      hs_rdata = 16'h5A5A;
      hs_done  = 1'b1;
      tick();
      hs_done  = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h5A5A) begin
         errors++; $display("FAIL gd_rsp: valid=%b data=%h want 1 5a5a", rsp_valid, rsp_data);
      end
      wait_idle("gd_drain", extra);
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL gd_once: %0d extra request cycles want 0", extra); end
   endtask

   task automatic test_done_through_gap;
      int extra;
      push_cmd(1'b1, 22'h000222, 16'h1111);
      push_cmd(1'b1, 22'h000333, 16'h2222);
      checks++;
      if (hs_wr !== 1'b1 || hs_addr !== 22'h000222) begin
         errors++; $display("FAIL dg_first: wr=%b addr=%h want 1 000222", hs_wr, hs_addr);
      end
      hs_done = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({hs_rd, hs_wr} !== 2'b00) begin
            errors++; $display("FAIL dg_hold%0d: rd,wr=%b want 00 while done high", i, {hs_rd, hs_wr});
         end
         tick();
      end
      hs_done = 1'b0;
      tick();
      checks++;
      if ({hs_rd, hs_wr} !== 2'b00) begin errors++; $display("FAIL dg_idle: rd,wr=%b want 00", {hs_rd, hs_wr}); end
      tick();
      checks++;
      if (hs_wr !== 1'b1 || hs_addr !== 22'h000333 || hs_data !== 16'h2222) begin
         errors++; $display("FAIL dg_second: wr=%b addr=%h data=%h want 1 000333 2222", hs_wr, hs_addr, hs_data);
      end
      hs_done = 1'b1;
      tick();
      hs_done = 1'b0;
      wait_idle("dg_drain", extra);
   endtask

`ifdef SEQ_TIMEOUT_EN
   task automatic test_timeout;
      int  cnt;
      int  extra;
      logic seen;
      push_cmd(1'b0, 22'h000444, 16'h0000);
      push_cmd(1'b1, 22'h000555, 16'h3333);
      cnt  = hs_rd ? 1 : 0;
      seen = 1'b0;
      for (int n = 0; n < 40 && hs_rd; n++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
         if (hs_rd) cnt++;
      end
      checks++;
      if (cnt !== 16) begin errors++; $display("FAIL to_len: rd high %0d cycles want 16", cnt); end
      checks++;
      if (err !== 1'b1 || seen !== 1'b0) begin
         errors++; $display("FAIL to_err: err=%b rsp_seen=%b want 1 0", err, seen);
      end
      wait_req("to_next");
      checks++;
      if (hs_wr !== 1'b1 || hs_addr !== 22'h000555 || err !== 1'b1) begin
         errors++; $display("FAIL to_next: wr=%b addr=%h err=%b want 1 000555 1", hs_wr, hs_addr, err);
      end
      hs_done = 1'b1;
      tick();
      hs_done = 1'b0;
      wait_idle("to_drain", extra);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL to_sticky: err=%b want 1", err); end
   endtask
`endif

   task automatic test_reset_mid_req;
      int seen;
      push_cmd(1'b0, 22'h000666, 16'h0000);
      push_cmd(1'b0, 22'h000777, 16'h0000);
      checks++;
      if (hs_rd !== 1'b1) begin errors++; $display("FAIL rst_pre: rd=%b want 1", hs_rd); end
      rst = 1'b1;
      tick();
      checks++;
      if ({hs_rd, hs_wr, err, busy, cmd_ready} !== 5'b00001 || rsp_data !== 16'h0000) begin
         errors++; $display("FAIL rst_mid: rd,wr,err,busy,ready=%b rsp_data=%h want 00001 0000",
                            {hs_rd, hs_wr, err, busy, cmd_ready}, rsp_data);
      end
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (hs_rd || hs_wr || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL rst_flush: %0d active cycles after reset want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_grant_drop();
      test_done_through_gap();
`ifdef SEQ_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_req();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
